cpu_axi_bridge: RTL and testbench

Parametrised successor to the single-transaction SRAM-like-to-AXI3 interface: bridges the CPU's inst and data SRAM-like ports onto one 32-bit AXI master. Unlike the previous generation, it supports:

- multiple outstanding reads per port, tagged by AXI ID;
- a posted write buffer with early write acknowledgement;
- read-after-write address hazard blocking against every buffered write.

It sits between the CPU core and the AXI crossbar.

---
 rtl/cpu_axi_bridge_if.sv | 74 +++++++
 rtl/cpu_axi_bridge.sv | 237 +++++++++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_axi_bridge_if.sv
// cpu_axi_bridge_if: AXI3 single-master bus bundle used by cpu_axi_bridge.
// Carries the AR/R/AW/W/B channels of one 32-bit AXI port.
//   master modport: the bridge side. It drives AR/AW/W payload and valid,
//                   rready and bready, and samples the ready/response inputs.
//   slave  modport: the interconnect/memory side.
interface cpu_axi_bridge_if;
    // AR channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    // R channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    // AW channel
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    // W channel
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    // B channel
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: bridges the CPU inst and data SRAM-like ports onto one
// 32-bit AXI3 master. Each port may have up to RD_MAX reads in flight,
// tagged by ARID (inst=0, data=1). Data writes are posted: they are
// acknowledged one cycle after acceptance and held in a WR_MAX-deep buffer
// until their B response. Reads that hit a buffered word address wait.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   inst_*            inst SRAM-like port (reads only)
//   data_*            data SRAM-like port (reads and writes)
//   axi               AXI master (cpu_axi_bridge_if.master)
module cpu_axi_bridge #(
    parameter int RD_MAX = 2,
    parameter int WR_MAX = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inst_req,
    input  logic                    inst_wr,
    input  logic [1:0]              inst_size,
    input  logic [31:0]             inst_addr,
    input  logic [31:0]             inst_wdata,
    output logic [31:0]             inst_rdata,
    output logic                    inst_addr_ok,
    output logic                    inst_data_ok,
    input  logic                    data_req,
    input  logic                    data_wr,
    input  logic [1:0]              data_size,
    input  logic [31:0]             data_addr,
    input  logic [31:0]             data_wdata,
    output logic [31:0]             data_rdata,
    output logic                    data_addr_ok,
    output logic                    data_data_ok,
    cpu_axi_bridge_if.master        axi
);

    // Byte strobes for a write of the given size at the given byte offset.
    function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] s;
        case ({size, lo})
            4'b00_00: s = 4'b0001;
            4'b00_01: s = 4'b0010;
            4'b00_10: s = 4'b0100;
            4'b00_11: s = 4'b1000;
            4'b01_00: s = 4'b0011;
            4'b01_10: s = 4'b1100;
            4'b10_00: s = 4'b1111;
            default:  s = 4'b0000;
        endcase
        return s;
    endfunction

    logic        arvalid_r;
    logic [31:0] araddr_r;
    logic [1:0]  arsize_r;
    logic        arid_r;
    logic [3:0]  inst_cnt_r;
    logic [3:0]  data_cnt_r;
    logic        awvalid_r;
    logic [31:0] awaddr_r;
    logic [1:0]  awsize_r;
    logic        wvalid_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        wr_ok_r;
    logic [29:0] wb_addr_r [WR_MAX];
    logic [WR_MAX-1:0] wb_valid_r;
    logic [2:0]  wb_head_r;
    logic [2:0]  wb_tail_r;
    logic [3:0]  wb_occ_r;

    logic inst_hit_s, data_hit_s, ar_free_s, data_rd_ok_s, data_wr_ok_s;
    logic inst_rd_acc_s, data_rd_acc_s, wr_acc_s, push_s, pop_s;
    logic inst_rsp_s, data_rsp_s;
    logic unused_s;

    assign unused_s = ^{inst_wdata, axi.rresp, axi.rlast, axi.bid, axi.bresp};

    // Word-address hazard of each port's read against every buffered write.
    always_comb begin
        inst_hit_s = 1'b0;
        data_hit_s = 1'b0;
        for (int i = 0; i < WR_MAX; i++) begin
            inst_hit_s = inst_hit_s | (wb_valid_r[i] && (wb_addr_r[i] == inst_addr[31:2]));
            data_hit_s = data_hit_s | (wb_valid_r[i] && (wb_addr_r[i] == data_addr[31:2]));
        end
    end

    // The AR register can take a new read if it is empty or drains this cycle.
    assign ar_free_s    = !arvalid_r || axi.arready;
    assign data_rd_ok_s = !reset && ar_free_s && (data_cnt_r < 4'(RD_MAX)) && !data_hit_s;
    assign data_wr_ok_s = !reset && (data_cnt_r == 4'd0) && (wb_occ_r < 4'(WR_MAX))
                          && !awvalid_r && !wvalid_r;
    assign data_addr_ok = data_wr ? data_wr_ok_s : data_rd_ok_s;
    // A pending data read wins the AR register over inst.
    assign inst_addr_ok = !reset && !inst_wr && ar_free_s && (inst_cnt_r < 4'(RD_MAX))
                          && !inst_hit_s && !(data_req && !data_wr && data_rd_ok_s);

    assign inst_rd_acc_s = inst_req && inst_addr_ok;
    assign data_rd_acc_s = data_req && !data_wr && data_addr_ok;
    assign wr_acc_s      = data_req && data_wr && data_addr_ok;
    assign push_s        = wr_acc_s;
    assign pop_s         = axi.bvalid && (wb_occ_r != 4'd0);

    // Responses count only while a read is outstanding, so stale beats after reset are dropped.
    assign inst_rsp_s   = axi.rvalid && (axi.rid == 4'd0) && (inst_cnt_r != 4'd0);
    assign data_rsp_s   = axi.rvalid && (axi.rid == 4'd1) && (data_cnt_r != 4'd0);
    assign inst_data_ok = inst_rsp_s;
    assign data_data_ok = data_rsp_s || wr_ok_r;
    assign inst_rdata   = axi.rdata;
    assign data_rdata   = axi.rdata;

    assign axi.arid    = {3'd0, arid_r};
    assign axi.araddr  = araddr_r;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, arsize_r};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = arvalid_r;
    assign axi.rready  = 1'b1;
    assign axi.awid    = 4'd1;
    assign axi.awaddr  = awaddr_r;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, awsize_r};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = awvalid_r;
    assign axi.wid     = 4'd1;
    assign axi.wdata   = wdata_r;
    assign axi.wstrb   = wstrb_r;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_r;
    assign axi.bready  = 1'b1;

    // AR staging register and per-port outstanding read counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arvalid_r  <= 1'b0;
            araddr_r   <= 32'd0;
            arsize_r   <= 2'd0;
            arid_r     <= 1'b0;
            inst_cnt_r <= 4'd0;
            data_cnt_r <= 4'd0;
        end else begin
            if (data_rd_acc_s) begin
                arvalid_r <= 1'b1;
                araddr_r  <= data_addr;
                arsize_r  <= data_size;
                arid_r    <= 1'b1;
            end else if (inst_rd_acc_s) begin
                arvalid_r <= 1'b1;
                araddr_r  <= inst_addr;
                arsize_r  <= inst_size;
                arid_r    <= 1'b0;
            end else if (axi.arready) begin
                arvalid_r <= 1'b0;
            end
            case ({inst_rd_acc_s, inst_rsp_s})
                2'b10:   inst_cnt_r <= inst_cnt_r + 4'd1;
                2'b01:   inst_cnt_r <= inst_cnt_r - 4'd1;
                default: inst_cnt_r <= inst_cnt_r;
            endcase
            case ({data_rd_acc_s, data_rsp_s})
                2'b10:   data_cnt_r <= data_cnt_r + 4'd1;
                2'b01:   data_cnt_r <= data_cnt_r - 4'd1;
                default: data_cnt_r <= data_cnt_r;
            endcase
        end
    end

    // AW/W staging registers and the posted-write acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awvalid_r <= 1'b0;
            awaddr_r  <= 32'd0;
            awsize_r  <= 2'd0;
            wvalid_r  <= 1'b0;
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
            wr_ok_r   <= 1'b0;
        end else begin
            wr_ok_r <= wr_acc_s;
            if (wr_acc_s) begin
                awvalid_r <= 1'b1;
                awaddr_r  <= data_addr;
                awsize_r  <= data_size;
                wvalid_r  <= 1'b1;
                wdata_r   <= data_wdata;
                wstrb_r   <= wstrb_of(data_size, data_addr[1:0]);
            end else begin
                if (axi.awready) begin
                    awvalid_r <= 1'b0;
                end
                if (axi.wready) begin
                    wvalid_r <= 1'b0;
                end
            end
        end
    end

    // Write buffer: circular FIFO of word addresses awaiting their B response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_r <= '0;
            wb_head_r  <= 3'd0;
            wb_tail_r  <= 3'd0;
            wb_occ_r   <= 4'd0;
            for (int i = 0; i < WR_MAX; i++) begin
                wb_addr_r[i] <= 30'd0;
            end
        end else begin
            for (int i = 0; i < WR_MAX; i++) begin
                if (push_s && (3'(i) == wb_tail_r)) begin
                    wb_valid_r[i] <= 1'b1;
                    wb_addr_r[i]  <= data_addr[31:2];
                end else if (pop_s && (3'(i) == wb_head_r)) begin
                    wb_valid_r[i] <= 1'b0;
                end
            end
            if (push_s) begin
                wb_tail_r <= (wb_tail_r == 3'(WR_MAX - 1)) ? 3'd0 : wb_tail_r + 3'd1;
            end
            if (pop_s) begin
                wb_head_r <= (wb_head_r == 3'(WR_MAX - 1)) ? 3'd0 : wb_head_r + 3'd1;
            end
            case ({push_s, pop_s})
                2'b10:   wb_occ_r <= wb_occ_r + 4'd1;
                2'b01:   wb_occ_r <= wb_occ_r - 4'd1;
                default: wb_occ_r <= wb_occ_r;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed bench for cpu_axi_bridge (RD_MAX=2, WR_MAX=4).
// The bench plays the AXI slave by hand; inputs change on the falling edge
// and outputs are sampled 1 time unit later.
module tb_cpu_axi_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    int          errors = 0;
    int          checks = 0;

    cpu_axi_bridge_if axi();

    cpu_axi_bridge #(.RD_MAX(2), .WR_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .axi(axi)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'd0; inst_wdata = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'd0; data_wdata = 32'd0;
        axi.arready = 1'b1; axi.rvalid = 1'b0; axi.rid = 4'd0; axi.rdata = 32'd0;
        axi.rresp = 2'd0; axi.rlast = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
        axi.bvalid = 1'b0; axi.bid = 4'd1; axi.bresp = 2'd0;

        // Reset state
        repeat (2) step();
        #1;
        check_eq("rst_arvalid", 32'(axi.arvalid), 32'd0);
        check_eq("rst_awvalid", 32'(axi.awvalid), 32'd0);
        check_eq("rst_wvalid", 32'(axi.wvalid), 32'd0);
        check_eq("rst_rready", 32'(axi.rready), 32'd1);
        check_eq("rst_bready", 32'(axi.bready), 32'd1);
        check_eq("rst_inst_aok", 32'(inst_addr_ok), 32'd0);
        check_eq("rst_data_dok", 32'(data_data_ok), 32'd0);
        check_eq("rst_araddr", axi.araddr, 32'd0);
        step(); reset = 1'b0;

        // Back-to-back inst reads: third is held until the first response
        step(); inst_req = 1'b1; inst_addr = 32'h10; #1;
        check_eq("a_ok0", 32'(inst_addr_ok), 32'd1);
        step(); inst_addr = 32'h14; #1;
        check_eq("a_arvalid", 32'(axi.arvalid), 32'd1);
        check_eq("a_araddr0", axi.araddr, 32'h10);
        check_eq("a_arid0", 32'(axi.arid), 32'd0);
        check_eq("a_ok1", 32'(inst_addr_ok), 32'd1);
        step(); inst_addr = 32'h18; #1;
        check_eq("a_full", 32'(inst_addr_ok), 32'd0);
        check_eq("a_araddr1", axi.araddr, 32'h14);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            check_eq("a_hold", 32'(inst_addr_ok), 32'd0);
        end
        step(); axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'hA0; #1;
        check_eq("a_dok0", 32'(inst_data_ok), 32'd1);
        check_eq("a_rdata0", inst_rdata, 32'hA0);
        check_eq("a_held", 32'(inst_addr_ok), 32'd0);
        check_eq("a_no_ddok", 32'(data_data_ok), 32'd0);
        step(); axi.rdata = 32'hA1; #1;
        check_eq("a_release", 32'(inst_addr_ok), 32'd1);
        check_eq("a_dok1", 32'(inst_data_ok), 32'd1);
        check_eq("a_rdata1", inst_rdata, 32'hA1);
        step(); inst_req = 1'b0; axi.rvalid = 1'b0; #1;
        check_eq("a_araddr2", axi.araddr, 32'h18);
        check_eq("a_arvalid2", 32'(axi.arvalid), 32'd1);
        check_eq("a_dok_idle", 32'(inst_data_ok), 32'd0);
        step(); axi.rvalid = 1'b1; axi.rdata = 32'hA2; #1;
        check_eq("a_dok2", 32'(inst_data_ok), 32'd1);

        // Simultaneous inst/data reads: data first, then inst; rid routing
        step(); axi.rvalid = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h100;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200; #1;
        check_eq("b_data_aok", 32'(data_addr_ok), 32'd1);
        check_eq("b_inst_blk", 32'(inst_addr_ok), 32'd0);
        step(); data_req = 1'b0; #1;
        check_eq("b_arid1", 32'(axi.arid), 32'd1);
        check_eq("b_araddr1", axi.araddr, 32'h200);
        check_eq("b_inst_aok", 32'(inst_addr_ok), 32'd1);
        step(); inst_req = 1'b0; #1;
        check_eq("b_arid0", 32'(axi.arid), 32'd0);
        check_eq("b_araddr0", axi.araddr, 32'h100);
        step(); axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'hB0; #1;
        check_eq("b_inst_dok", 32'(inst_data_ok), 32'd1);
        check_eq("b_data_dok0", 32'(data_data_ok), 32'd0);
        step(); axi.rid = 4'd1; axi.rdata = 32'hB1; #1;
        check_eq("b_data_dok", 32'(data_data_ok), 32'd1);
        check_eq("b_inst_dok0", 32'(inst_data_ok), 32'd0);
        check_eq("b_data_rdata", data_rdata, 32'hB1);

        // Posted write to 0x80, then a read of 0x80 blocked until B
        step(); axi.rvalid = 1'b0; axi.rid = 4'd0;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80; data_size = 2'd2;
        data_wdata = 32'h1234_5678; #1;
        check_eq("c_wr_aok", 32'(data_addr_ok), 32'd1);
        step(); data_wr = 1'b0; #1;
        check_eq("c_posted_dok", 32'(data_data_ok), 32'd1);
        check_eq("c_awvalid", 32'(axi.awvalid), 32'd1);
        check_eq("c_wvalid", 32'(axi.wvalid), 32'd1);
        check_eq("c_awaddr", axi.awaddr, 32'h80);
        check_eq("c_wdata", axi.wdata, 32'h1234_5678);
        check_eq("c_wstrb", 32'(axi.wstrb), 32'hF);
        check_eq("c_awsize", 32'(axi.awsize), 32'd2);
        check_eq("c_hazard", 32'(data_addr_ok), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(); #1;
            check_eq("c_blocked", 32'(data_addr_ok), 32'd0);
        end
        check_eq("c_dok_once", 32'(data_data_ok), 32'd0);
        step(); axi.bvalid = 1'b1; #1;
        check_eq("c_blocked_b", 32'(data_addr_ok), 32'd0);
        step(); axi.bvalid = 1'b0; #1;
        check_eq("c_unblocked", 32'(data_addr_ok), 32'd1);
        step(); data_req = 1'b0; #1;
        check_eq("c_araddr", axi.araddr, 32'h80);
        check_eq("c_arid", 32'(axi.arid), 32'd1);
        step(); axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rdata = 32'h1234_5678; #1;
        check_eq("c_rd_dok", 32'(data_data_ok), 32'd1);
        check_eq("c_rd_data", data_rdata, 32'h1234_5678);
        step(); axi.rvalid = 1'b0;

        // Write buffer full: four writes accepted, fifth stalls until one B
        for (int i = 0; i < 4; i++) begin
            step(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
            data_addr = 32'h400 + 32'(4 * i); #1;
            check_eq("d_accept", 32'(data_addr_ok), 32'd1);
            step(); data_req = 1'b0; #1;
            check_eq("d_stage_busy", 32'(data_addr_ok), 32'd0);
        end
        step(); data_req = 1'b1; data_addr = 32'h410; #1;
        check_eq("d_full", 32'(data_addr_ok), 32'd0);
        step(); #1;
        check_eq("d_full2", 32'(data_addr_ok), 32'd0);
        step(); axi.bvalid = 1'b1; #1;
        check_eq("d_full_b", 32'(data_addr_ok), 32'd0);
        step(); axi.bvalid = 1'b0; #1;
        check_eq("d_release", 32'(data_addr_ok), 32'd1);
        step(); data_req = 1'b0; axi.bvalid = 1'b1;
        repeat (4) step();

        // wstrb patterns; AW and W handshakes in separate cycles
        axi.bvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h503;
        data_wdata = 32'hAABB_CCDD; #1;
        check_eq("e_accept0", 32'(data_addr_ok), 32'd1);
        step(); data_req = 1'b0; axi.awready = 1'b1; #1;
        check_eq("e_wstrb_b3", 32'(axi.wstrb), 32'h8);
        check_eq("e_awvalid", 32'(axi.awvalid), 32'd1);
        check_eq("e_wvalid", 32'(axi.wvalid), 32'd1);
        step(); axi.awready = 1'b0; axi.wready = 1'b1; #1;
        check_eq("e_aw_done", 32'(axi.awvalid), 32'd0);
        check_eq("e_w_pending", 32'(axi.wvalid), 32'd1);
        check_eq("e_stall", 32'(data_addr_ok), 32'd0);
        step(); axi.wready = 1'b0; #1;
        check_eq("e_nodup_aw", 32'(axi.awvalid), 32'd0);
        check_eq("e_nodup_w", 32'(axi.wvalid), 32'd0);
        step(); axi.awready = 1'b1; axi.wready = 1'b1;
        data_req = 1'b1; data_size = 2'd1; data_addr = 32'h602; #1;
        check_eq("e_accept1", 32'(data_addr_ok), 32'd1);
        step(); data_req = 1'b0; #1;
        check_eq("e_wstrb_h1", 32'(axi.wstrb), 32'hC);
        step(); data_req = 1'b1; data_size = 2'd2; data_addr = 32'h701; #1;
        check_eq("e_accept2", 32'(data_addr_ok), 32'd1);
        step(); data_req = 1'b0; #1;
        check_eq("e_wstrb_bad", 32'(axi.wstrb), 32'h0);
        check_eq("e_bad_issued", 32'(axi.awvalid), 32'd1);

        // Reset with three writes and two reads outstanding
        step(); data_wr = 1'b0; inst_req = 1'b1; inst_addr = 32'h900; #1;
        check_eq("f_ok0", 32'(inst_addr_ok), 32'd1);
        step(); inst_addr = 32'h904; #1;
        check_eq("f_ok1", 32'(inst_addr_ok), 32'd1);
        step(); inst_req = 1'b0; axi.arready = 1'b0; #1;
        check_eq("f_arvalid", 32'(axi.arvalid), 32'd1);
        #1; reset = 1'b1; #1;
        check_eq("f_rst_arvalid", 32'(axi.arvalid), 32'd0);
        check_eq("f_rst_araddr", axi.araddr, 32'd0);
        check_eq("f_rst_inst_aok", 32'(inst_addr_ok), 32'd0);
        check_eq("f_rst_data_dok", 32'(data_data_ok), 32'd0);
        step(); reset = 1'b0; axi.arready = 1'b1;
        axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'hDEAD; axi.bvalid = 1'b1; #1;
        check_eq("f_stale_dok", 32'(inst_data_ok), 32'd0);
        check_eq("f_hazard_clr", 32'(data_addr_ok), 32'd1);
        step(); axi.rvalid = 1'b0; axi.bvalid = 1'b0; inst_req = 1'b1; inst_addr = 32'h900; #1;
        check_eq("f_new_aok", 32'(inst_addr_ok), 32'd1);
        step(); inst_req = 1'b0; #1;
        check_eq("f_new_araddr", axi.araddr, 32'h900);
        step(); axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'hCAFE; #1;
        check_eq("f_new_dok", 32'(inst_data_ok), 32'd1);
        check_eq("f_new_rdata", inst_rdata, 32'hCAFE);
        step(); axi.rvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
